// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-side PC sequencer.
package pc_seq_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  // Sequencer control states.
  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_HOLD,
    ST_FLUSH
  } state_e;

  // Winning redirect source for the current cycle.
  typedef enum logic [1:0] {
    SRC_SEQ,
    SRC_BRANCH,
    SRC_MRET,
    SRC_TRAP
  } redir_src_e;

endpackage

// File: rtl/pc_redirect_mux.sv
// Fixed-priority redirect select: trap > mret > branch. Purely combinational.
module pc_redirect_mux
  import pc_seq_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'('h100)
) (
  input  logic            trap,
  input  logic            mret,
  input  logic [XLEN-1:0] mepc,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            hit,
  output logic [XLEN-1:0] target
);

  redir_src_e src;

  // Pick the highest-priority active source, then its target address.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    src    = SRC_SEQ;
    target = '0;
    if (trap)              src = SRC_TRAP;
    else if (mret)         src = SRC_MRET;
    else if (branch_taken) src = SRC_BRANCH;

    case (src)
      SRC_TRAP:   target = TRAP_VEC;
      SRC_MRET:   target = mepc;
      SRC_BRANCH: target = branch_target;
      default:    target = '0;
    endcase
    hit = (src != SRC_SEQ);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC generation and single-outstanding instruction fetch handshake.
// A redirect that arrives while a fetch is in flight squashes that fetch;
// the request stays stable at the old address until memory completes it.
module pc_sequencer #(
  parameter int unsigned     XLEN      = pc_seq_pkg::XLEN,
  parameter logic [XLEN-1:0] BOOT_ADDR = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            trap,
  input  logic            mret,
  input  logic [XLEN-1:0] mepc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc_out,
  output logic            fetch_valid
);

  import pc_seq_pkg::*;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

  state_e          state_q, state_d;
  logic            busy_q, busy_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;

  logic            redir_hit;
  logic [XLEN-1:0] redir_target;
  logic            req;
  logic            valid;

  pc_redirect_mux #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC)
  ) u_redirect_mux (
    .trap          (trap),
    .mret          (mret),
    .mepc          (mepc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .hit           (redir_hit),
    .target        (redir_target)
  );

  // Next-state, next-PC and handshake outputs.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    req     = 1'b0;
    valid   = 1'b0;

    case (state_q)
      // One idle cycle after reset; redirects are ignored here.
      ST_BOOT: state_d = ST_FETCH;

      ST_FETCH: begin
        // An outstanding fetch keeps requesting even under stall.
        req = busy_q | ~stall;
        if (req && imem_ready) begin
          busy_d = 1'b0;
          if (redir_hit) begin
            pc_d = redir_target;           // squash the returning fetch
          end else begin
            valid = 1'b1;
            pc_d  = pc_q + PC_STEP;        // wraps modulo 2^XLEN
          end
        end else if (req) begin
          busy_d = 1'b1;
          if (redir_hit) begin
            pend_d  = redir_target;        // address must stay put until ready
            state_d = ST_FLUSH;
          end
        end else begin
          if (redir_hit) pc_d = redir_target;
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (redir_hit) pc_d = redir_target;
        if (!stall)    state_d = ST_FETCH;
      end

      ST_FLUSH: begin
        req = 1'b1;
        if (redir_hit) pend_d = redir_target;  // latest redirect wins
        if (imem_ready) begin
          busy_d  = 1'b0;
          pc_d    = redir_hit ? redir_target : pend_q;
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_BOOT;
    endcase
  end

  // Registered control state; reset also discards any pending target.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) begin
      state_q <= ST_BOOT;
      busy_q  <= 1'b0;
      pc_q    <= BOOT_ADDR;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  assign imem_req    = req;
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign fetch_valid = valid;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: inputs change just after the falling
// edge, outputs are sampled 1ns later, well away from the rising edge.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        trap;
  logic        mret;
  logic [31:0] mepc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] pc_out;
  logic        fetch_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .XLEN      (32),
    .BOOT_ADDR (32'h0000_0000),
    .TRAP_VEC  (32'h0000_0100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .trap          (trap),
    .mret          (mret),
    .mepc          (mepc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .pc_out        (pc_out),
    .fetch_valid   (fetch_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then clear all redirect inputs.
  task automatic next_cycle();
    @(negedge clk);
    branch_taken = 1'b0;
    trap         = 1'b0;
    mret         = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    bit seen;
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    trap = 1'b0; mret = 1'b0; mepc = 32'h200; imem_ready = 1'b1;

    // Reset values
    @(negedge clk); settle();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_fv", 32'(fetch_valid), 32'd0);

    // Release: BOOT cycle without request, then sequential fetch
    @(negedge clk); reset = 1'b1; settle();
    check("boot_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      next_cycle(); settle();
      check($sformatf("seq%0d_req", i), 32'(imem_req), 32'd1);
      check($sformatf("seq%0d_addr", i), imem_addr, 32'(i * 4));
      check($sformatf("seq%0d_fv", i), 32'(fetch_valid), 32'd1);
    end

    // At 0x10: ready low 3 cycles, trap during first wait cycle
    next_cycle(); imem_ready = 1'b0; trap = 1'b1; settle();
    check("w1_addr", imem_addr, 32'h10);
    check("w1_fv", 32'(fetch_valid), 32'd0);
    next_cycle(); settle();
    check("w2_addr", imem_addr, 32'h10);
    check("w2_req", 32'(imem_req), 32'd1);
    next_cycle(); settle();
    check("w3_addr", imem_addr, 32'h10);
    next_cycle(); imem_ready = 1'b1; settle();
    check("trap_done_addr", imem_addr, 32'h10);
    check("trap_done_fv", 32'(fetch_valid), 32'd0);
    next_cycle(); settle();
    check("trap_vec_addr", imem_addr, 32'h100);
    check("trap_vec_fv", 32'(fetch_valid), 32'd1);

    // Branch back to 0x8, then branch at 0x8 to 0x40
    branch_taken = 1'b1; branch_target = 32'h8; settle();
    check("br8_fv", 32'(fetch_valid), 32'd0);
    next_cycle(); branch_taken = 1'b1; branch_target = 32'h40; settle();
    check("at8_addr", imem_addr, 32'h8);
    check("at8_squash", 32'(fetch_valid), 32'd0);
    next_cycle(); settle();
    check("br40_addr", imem_addr, 32'h40);

    // Simultaneous trap, mret and branch: trap wins
    trap = 1'b1; mret = 1'b1; mepc = 32'h200; branch_taken = 1'b1; branch_target = 32'h40; settle();
    check("prio_fv", 32'(fetch_valid), 32'd0);
    next_cycle(); settle();
    check("prio_pc", pc_out, 32'h100);

    // Move to 0x20, then stall two cycles while idle
    branch_taken = 1'b1; branch_target = 32'h20; settle();
    next_cycle(); stall = 1'b1; settle();
    check("st1_req", 32'(imem_req), 32'd0);
    check("st1_pc", pc_out, 32'h20);
    next_cycle(); settle();
    check("st2_req", 32'(imem_req), 32'd0);
    check("st2_pc", pc_out, 32'h20);
    next_cycle(); stall = 1'b0; settle();
    seen = imem_req;
    for (int i = 0; i < 4 && !seen; i++) begin
      next_cycle(); settle();
      seen = imem_req;
    end
    check("unstall_req_seen", 32'(seen), 32'd1);
    check("unstall_addr", imem_addr, 32'h20);
    check("unstall_fv", 32'(fetch_valid), 32'd1);

    // Wrap-around at the top of the address space
    next_cycle(); branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; settle();
    check("pre_wrap_addr", imem_addr, 32'h24);
    next_cycle(); settle();
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    check("top_fv", 32'(fetch_valid), 32'd1);
    next_cycle(); settle();
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_fv", 32'(fetch_valid), 32'd1);

    // FLUSH: branch then mret while waiting; the later redirect wins
    next_cycle(); imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h40; settle();
    check("fl_addr0", imem_addr, 32'h4);
    next_cycle(); mret = 1'b1; mepc = 32'h200; settle();
    check("fl_addr1", imem_addr, 32'h4);
    next_cycle(); imem_ready = 1'b1; settle();
    check("fl_done_fv", 32'(fetch_valid), 32'd0);
    next_cycle(); settle();
    check("fl_latest_addr", imem_addr, 32'h200);
    check("fl_latest_fv", 32'(fetch_valid), 32'd1);

    // Reset asserted during FLUSH discards the pending target
    next_cycle(); imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h80; settle();
    next_cycle(); settle();
    check("rf_addr", imem_addr, 32'h204);
    check("rf_req", 32'(imem_req), 32'd1);
    #1 reset = 1'b0; settle();
    check("rf_rst_req", 32'(imem_req), 32'd0);
    check("rf_rst_pc", pc_out, 32'h0);
    check("rf_rst_fv", 32'(fetch_valid), 32'd0);
    next_cycle(); reset = 1'b1; imem_ready = 1'b1; settle();
    check("rf_boot_req", 32'(imem_req), 32'd0);
    next_cycle(); settle();
    check("rf_first_addr", imem_addr, 32'h0);
    check("rf_first_fv", 32'(fetch_valid), 32'd1);
    next_cycle(); settle();
    check("rf_second_addr", imem_addr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
